pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage pipelined RISC-V core. It arbitrates three competing pipeline events: data-memory wait, taken branch/jump resolved in EX, and load-use hazard. It drives the pipeline-register write enables and flush/bubble controls from that arbitration. It also tracks memory-wait duration with a timeout monitor and keeps saturating performance counters for each event class.

---
 rtl/pipeline_stall_controller.sv | 195 +++++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//
// Central stall/flush sequencer for the 5-stage RISC-V pipeline. Three events
// compete for the pipeline each cycle: data-memory wait (freeze), a taken
// branch/jump resolved in EX, and a load-use hazard. The highest-priority event
// decides the pipeline-register enables and the flush/bubble controls.
// A small FSM measures how long the memory wait has lasted and raises a sticky
// timeout flag. Three saturating counters record the cycles each event won.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   IF_ID_RegisterRs1/Rs2       source registers of the instruction in ID
//   ID_EX_RegisterRd            destination register of the instruction in EX
//   ID_EX_MemRead               instruction in EX is a load
//   EX_BranchTaken              branch/jump in EX resolved taken
//   MEM_Req, MEM_Ready          data-memory request / completion in MEM
//   counters_clear              clears the performance counters and mem_timeout
//   PCWrite, IF_ID_Write        PC and IF/ID update enables
//   IF_ID_Flush, ID_EX_Flush    NOP into IF/ID, bubble into ID/EX
//   EX_MEM_Write                ID/EX and EX/MEM update enable
//   MEM_WB_Bubble               bubble into MEM/WB
//   mem_timeout                 sticky flag: memory wait reached MEM_TIMEOUT
//   load_use_cnt, flush_cnt,
//   mem_wait_cnt                saturating performance counters
module pipeline_stall_controller #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_RegisterRs1,
  input  logic [4:0]       IF_ID_RegisterRs2,
  input  logic [4:0]       ID_EX_RegisterRd,
  input  logic             ID_EX_MemRead,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Req,
  input  logic             MEM_Ready,
  input  logic             counters_clear,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
);

  // Wide enough to hold the value MEM_TIMEOUT itself.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO  = WAIT_W'(0);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  logic              freeze_s;
  logic              load_use_s;
  logic              win_freeze_s;
  logic              win_branch_s;
  logic              win_load_use_s;
  logic [0:0]        state_r;
  logic [0:0]        state_next_s;
  logic [WAIT_W-1:0] wait_ctr_r;
  logic [WAIT_W-1:0] wait_next_s;
  logic              timeout_set_s;
  logic              mem_timeout_r;
  logic [CNT_W-1:0]  load_use_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;
  logic [CNT_W-1:0]  mem_wait_cnt_r;

  // Increment by one unless already at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             en);
    if (en && (cnt != {CNT_W{1'b1}})) begin
      return cnt + CNT_W'(1);
    end else begin
      return cnt;
    end
  endfunction

  // Event detection and priority resolution (reset is handled separately).
  always_comb begin
    freeze_s   = MEM_Req & ~MEM_Ready;
    // x0 is hardwired to zero, so a load into it never creates a hazard.
    load_use_s = ID_EX_MemRead & (ID_EX_RegisterRd != 5'd0) &
                 ((ID_EX_RegisterRd == IF_ID_RegisterRs1) |
                  (ID_EX_RegisterRd == IF_ID_RegisterRs2));
    win_freeze_s   = freeze_s;
    win_branch_s   = ~freeze_s & EX_BranchTaken;
    win_load_use_s = ~freeze_s & ~EX_BranchTaken & load_use_s;
  end

  // Pipeline control outputs, same-cycle from the winning event.
  always_comb begin
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    EX_MEM_Write  = 1'b1;
    MEM_WB_Bubble = 1'b0;
    if (reset) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      IF_ID_Flush   = 1'b1;
      ID_EX_Flush   = 1'b1;
      EX_MEM_Write  = 1'b0;
      MEM_WB_Bubble = 1'b1;
    end else if (win_freeze_s) begin
      // Whole pipeline holds; branch/load-use stay in place and are seen again
      // once memory completes.
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      MEM_WB_Bubble = 1'b1;
    end else if (win_branch_s) begin
      // The instructions in IF and ID are wrong-path: both are squashed.
      IF_ID_Flush   = 1'b1;
      ID_EX_Flush   = 1'b1;
    end else if (win_load_use_s) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Flush   = 1'b1;
    end else begin
      PCWrite       = 1'b1;
    end
  end

  // Memory-wait FSM next state and wait-duration counter.
  always_comb begin
    state_next_s = ST_RUN;
    wait_next_s  = WAIT_ZERO;
    case (state_r)
      ST_RUN: begin
        if (freeze_s) begin
          state_next_s = ST_MEM_WAIT;
          wait_next_s  = WAIT_ONE;
        end else begin
          state_next_s = ST_RUN;
          wait_next_s  = WAIT_ZERO;
        end
      end
      ST_MEM_WAIT: begin
        if (freeze_s) begin
          state_next_s = ST_MEM_WAIT;
          wait_next_s  = (wait_ctr_r == WAIT_LIMIT) ? wait_ctr_r : (wait_ctr_r + WAIT_ONE);
        end else begin
          state_next_s = ST_RUN;
          wait_next_s  = WAIT_ZERO;
        end
      end
      default: begin
        state_next_s = ST_RUN;
        wait_next_s  = WAIT_ZERO;
      end
    endcase
    // Raised on the edge where the count becomes MEM_TIMEOUT.
    timeout_set_s = freeze_s & (wait_next_s == WAIT_LIMIT);
  end

  // FSM state, wait counter, sticky timeout and performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_RUN;
      wait_ctr_r     <= WAIT_ZERO;
      mem_timeout_r  <= 1'b0;
      load_use_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r    <= {CNT_W{1'b0}};
      mem_wait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_next_s;
      wait_ctr_r <= wait_next_s;
      if (counters_clear) begin
        mem_timeout_r  <= 1'b0;
        load_use_cnt_r <= {CNT_W{1'b0}};
        flush_cnt_r    <= {CNT_W{1'b0}};
        mem_wait_cnt_r <= {CNT_W{1'b0}};
      end else begin
        mem_timeout_r  <= mem_timeout_r | timeout_set_s;
        load_use_cnt_r <= sat_inc(load_use_cnt_r, win_load_use_s);
        flush_cnt_r    <= sat_inc(flush_cnt_r, win_branch_s);
        mem_wait_cnt_r <= sat_inc(mem_wait_cnt_r, win_freeze_s);
      end
    end
  end

  assign mem_timeout  = mem_timeout_r;
  assign load_use_cnt = load_use_cnt_r;
  assign flush_cnt    = flush_cnt_r;
  assign mem_wait_cnt = mem_wait_cnt_r;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed self-checking bench for pipeline_stall_controller, built with
// CNT_W=4 and MEM_TIMEOUT=4 so saturation and timeout are reached quickly.
module tb_pipeline_stall_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IF_ID_RegisterRs1;
  logic [4:0] IF_ID_RegisterRs2;
  logic [4:0] ID_EX_RegisterRd;
  logic       ID_EX_MemRead;
  logic       EX_BranchTaken;
  logic       MEM_Req;
  logic       MEM_Ready;
  logic       counters_clear;
  logic       PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, MEM_WB_Bubble;
  logic       mem_timeout;
  logic [3:0] load_use_cnt, flush_cnt, mem_wait_cnt;
  logic [5:0] ctl;

  int total  = 0;
  int passed = 0;

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, MEM_WB_Bubble}
  localparam logic [5:0] C_RST = 6'b001101;
  localparam logic [5:0] C_FRZ = 6'b000001;
  localparam logic [5:0] C_BR  = 6'b111110;
  localparam logic [5:0] C_LU  = 6'b000110;
  localparam logic [5:0] C_RUN = 6'b110010;

  assign ctl = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, MEM_WB_Bubble};

  always #5 clk = ~clk;

  pipeline_stall_controller #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_RegisterRs1(IF_ID_RegisterRs1), .IF_ID_RegisterRs2(IF_ID_RegisterRs2),
    .ID_EX_RegisterRd(ID_EX_RegisterRd), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_BranchTaken(EX_BranchTaken), .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready),
    .counters_clear(counters_clear),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Write(EX_MEM_Write), .MEM_WB_Bubble(MEM_WB_Bubble),
    .mem_timeout(mem_timeout), .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt),
    .mem_wait_cnt(mem_wait_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IF_ID_RegisterRs1 = 5'd0; IF_ID_RegisterRs2 = 5'd0; ID_EX_RegisterRd = 5'd0;
    ID_EX_MemRead = 1'b0; EX_BranchTaken = 1'b0; MEM_Req = 1'b0; MEM_Ready = 1'b0;
    counters_clear = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ID_EX_MemRead = 1'b1; ID_EX_RegisterRd = rd;
    IF_ID_RegisterRs1 = rs1; IF_ID_RegisterRs2 = rs2;
  endtask

  task automatic clear_counters();
    counters_clear = 1'b1;
    tick();
    counters_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    MEM_Req = 1'b1; EX_BranchTaken = 1'b1; set_load_use(5'd5, 5'd5, 5'd0);
    #1;
    total++; if (ctl !== C_RST) $display("FAIL reset_ctl: got %b want %b", ctl, C_RST); else passed++;
    tick(); tick();
    total++; if ({load_use_cnt, flush_cnt, mem_wait_cnt} !== 12'h000)
      $display("FAIL reset_cnts: got %h want %h", {load_use_cnt, flush_cnt, mem_wait_cnt}, 12'h000); else passed++;
    total++; if (mem_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want %b", mem_timeout, 1'b0); else passed++;
    reset = 1'b0; idle();
    #1;
    total++; if (ctl !== C_RUN) $display("FAIL run_ctl: got %b want %b", ctl, C_RUN); else passed++;
    tick();
    total++; if ({load_use_cnt, flush_cnt, mem_wait_cnt} !== 12'h000)
      $display("FAIL idle_cnts: got %h want %h", {load_use_cnt, flush_cnt, mem_wait_cnt}, 12'h000); else passed++;
  endtask

  task automatic test_load_use();
    clear_counters();
    set_load_use(5'd5, 5'd5, 5'd0);
    #1;
    total++; if (ctl !== C_LU) $display("FAIL lu_rs1_ctl: got %b want %b", ctl, C_LU); else passed++;
    tick();
    ID_EX_MemRead = 1'b0;   // bubble now in EX
    #1;
    total++; if (ctl !== C_RUN) $display("FAIL lu_after_ctl: got %b want %b", ctl, C_RUN); else passed++;
    total++; if (load_use_cnt !== 4'd1) $display("FAIL lu_cnt1: got %0d want %0d", load_use_cnt, 4'd1); else passed++;
    tick();
    set_load_use(5'd7, 5'd3, 5'd7);
    #1;
    total++; if (ctl !== C_LU) $display("FAIL lu_rs2_ctl: got %b want %b", ctl, C_LU); else passed++;
    tick();
    ID_EX_MemRead = 1'b0;   // same register match but not a load
    #1;
    total++; if (ctl !== C_RUN) $display("FAIL nonload_ctl: got %b want %b", ctl, C_RUN); else passed++;
    tick();
    total++; if (load_use_cnt !== 4'd2) $display("FAIL lu_cnt2: got %0d want %0d", load_use_cnt, 4'd2); else passed++;
    idle();
  endtask

  task automatic test_x0();
    clear_counters();
    set_load_use(5'd0, 5'd0, 5'd0);
    #1;
    total++; if (ctl !== C_RUN) $display("FAIL x0_ctl: got %b want %b", ctl, C_RUN); else passed++;
    tick();
    total++; if (load_use_cnt !== 4'd0) $display("FAIL x0_cnt: got %0d want %0d", load_use_cnt, 4'd0); else passed++;
    idle();
  endtask

  task automatic test_branch_over_load_use();
    clear_counters();
    set_load_use(5'd5, 5'd5, 5'd0);
    EX_BranchTaken = 1'b1;
    #1;
    total++; if (ctl !== C_BR) $display("FAIL br_ctl: got %b want %b", ctl, C_BR); else passed++;
    tick();
    idle();
    #1;
    total++; if (flush_cnt !== 4'd1) $display("FAIL br_flush_cnt: got %0d want %0d", flush_cnt, 4'd1); else passed++;
    total++; if (load_use_cnt !== 4'd0) $display("FAIL br_lu_cnt: got %0d want %0d", load_use_cnt, 4'd0); else passed++;
  endtask

  task automatic test_freeze();
    clear_counters();
    MEM_Req = 1'b1; MEM_Ready = 1'b0; EX_BranchTaken = 1'b1;
    set_load_use(5'd5, 5'd5, 5'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (ctl !== C_FRZ) $display("FAIL frz_ctl[%0d]: got %b want %b", i, ctl, C_FRZ); else passed++;
      tick();
    end
    MEM_Ready = 1'b1;
    #1;
    total++; if (ctl !== C_BR) $display("FAIL release_ctl: got %b want %b", ctl, C_BR); else passed++;
    tick();
    idle();
    total++; if (mem_wait_cnt !== 4'd3) $display("FAIL frz_wait_cnt: got %0d want %0d", mem_wait_cnt, 4'd3); else passed++;
    total++; if (flush_cnt !== 4'd1) $display("FAIL frz_flush_cnt: got %0d want %0d", flush_cnt, 4'd1); else passed++;
    total++; if (load_use_cnt !== 4'd0) $display("FAIL frz_lu_cnt: got %0d want %0d", load_use_cnt, 4'd0); else passed++;
    total++; if (mem_timeout !== 1'b0) $display("FAIL frz_timeout: got %b want %b", mem_timeout, 1'b0); else passed++;
    // The wait count restarts after returning to RUN: another 3-cycle wait
    // must not reach the limit of 4.
    MEM_Req = 1'b1;
    tick(); tick(); tick();
    MEM_Req = 1'b0;
    total++; if (mem_timeout !== 1'b0) $display("FAIL frz2_timeout: got %b want %b", mem_timeout, 1'b0); else passed++;
    total++; if (mem_wait_cnt !== 4'd6) $display("FAIL frz2_wait_cnt: got %0d want %0d", mem_wait_cnt, 4'd6); else passed++;
    tick();
  endtask

  task automatic test_timeout();
    clear_counters();
    MEM_Req = 1'b1; MEM_Ready = 1'b0;
    tick(); tick(); tick();
    total++; if (mem_timeout !== 1'b0) $display("FAIL to_after3: got %b want %b", mem_timeout, 1'b0); else passed++;
    tick();
    total++; if (mem_timeout !== 1'b1) $display("FAIL to_after4: got %b want %b", mem_timeout, 1'b1); else passed++;
    tick();
    total++; if (mem_timeout !== 1'b1) $display("FAIL to_after5: got %b want %b", mem_timeout, 1'b1); else passed++;
    idle();
    tick(); tick();
    total++; if (mem_timeout !== 1'b1) $display("FAIL to_sticky: got %b want %b", mem_timeout, 1'b1); else passed++;
    total++; if (mem_wait_cnt !== 4'd5) $display("FAIL to_wait_cnt: got %0d want %0d", mem_wait_cnt, 4'd5); else passed++;
    clear_counters();
    total++; if (mem_timeout !== 1'b0) $display("FAIL to_cleared: got %b want %b", mem_timeout, 1'b0); else passed++;
    total++; if (mem_wait_cnt !== 4'd0) $display("FAIL to_cnt_cleared: got %0d want %0d", mem_wait_cnt, 4'd0); else passed++;
  endtask

  task automatic test_saturation();
    clear_counters();
    set_load_use(5'd9, 5'd9, 5'd9);
    for (int i = 0; i < 20; i++) tick();
    total++; if (load_use_cnt !== 4'd15) $display("FAIL sat_cnt: got %0d want %0d", load_use_cnt, 4'd15); else passed++;
    counters_clear = 1'b1;
    tick();
    counters_clear = 1'b0;
    total++; if (load_use_cnt !== 4'd0) $display("FAIL clr_over_inc: got %0d want %0d", load_use_cnt, 4'd0); else passed++;
    tick();
    total++; if (load_use_cnt !== 4'd1) $display("FAIL inc_after_clr: got %0d want %0d", load_use_cnt, 4'd1); else passed++;
    idle();
  endtask

  task automatic test_reset_mid_wait();
    clear_counters();
    MEM_Req = 1'b1; MEM_Ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    total++; if (ctl !== C_RST) $display("FAIL midrst_ctl: got %b want %b", ctl, C_RST); else passed++;
    tick();
    reset = 1'b0;
    #1;
    total++; if (ctl !== C_FRZ) $display("FAIL postrst_ctl: got %b want %b", ctl, C_FRZ); else passed++;
    total++; if (mem_wait_cnt !== 4'd0) $display("FAIL midrst_cnt: got %0d want %0d", mem_wait_cnt, 4'd0); else passed++;
    tick(); tick(); tick();
    total++; if (mem_timeout !== 1'b0) $display("FAIL postrst_to3: got %b want %b", mem_timeout, 1'b0); else passed++;
    total++; if (mem_wait_cnt !== 4'd3) $display("FAIL postrst_cnt: got %0d want %0d", mem_wait_cnt, 4'd3); else passed++;
    tick();
    total++; if (mem_timeout !== 1'b1) $display("FAIL postrst_to4: got %b want %b", mem_timeout, 1'b1); else passed++;
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_branch_over_load_use();
    test_freeze();
    test_timeout();
    test_saturation();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
